// File: rtl/conv_sequencer.sv
// Convolution sequencer: streams kernel and window words from a FIFO, issues one kernel
// row per round across the multiplier lanes, then folds lane sums through the final adder.

module conv_lane #(
  parameter int BIT_LENGTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ld,
  input  logic                  clr,
  input  logic                  track,
  input  logic [BIT_LENGTH-1:0] a_in,
  input  logic [BIT_LENGTH-1:0] b_in,
  input  logic                  rdy,
  output logic [BIT_LENGTH-1:0] a,
  output logic [BIT_LENGTH-1:0] b,
  output logic                  seen
);
  // Operands hold between loads; seen is sticky so repeated mReady pulses are harmless.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a    <= '0;
      b    <= '0;
      seen <= 1'b0;
    end else begin
      if (ld) begin
        a <= a_in;
        b <= b_in;
      end
      if (clr)              seen <= 1'b0;
      else if (track && rdy) seen <= 1'b1;
    end
  end
endmodule

module conv_sequencer #(
  parameter int BIT_LENGTH = 32,
  parameter int LANES      = 3,
  parameter int ADD_LAT    = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        cStart,
  output logic                        cReady,
  output logic                        fifo_rd,
  input  logic                        fifo_empty,
  input  logic [BIT_LENGTH-1:0]       fifo_data,
  output logic [LANES*BIT_LENGTH-1:0] mul_a,
  output logic [LANES*BIT_LENGTH-1:0] mul_b,
  output logic [LANES-1:0]            mStart,
  input  logic [LANES-1:0]            mReady,
  output logic                        lane_clr,
  input  logic [LANES*BIT_LENGTH-1:0] lane_sum,
  output logic                        finalAdd,
  output logic [BIT_LENGTH-1:0]       finalAddend,
  output logic                        sum_clr
);
  localparam int N  = LANES * LANES;
  localparam int NW = 2 * N;
  localparam int CW = $clog2(NW + 1);
  localparam int IW = $clog2(NW);
  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FADD, FWAIT, DONE} state_t;

  state_t                              state;
  logic [CW-1:0]                       rd_cnt, wr_cnt;
  logic                                rd_pend;
  logic [NW-1:0][BIT_LENGTH-1:0]       dbuf;
  logic [KW-1:0]                       row, k, row_sel;
  logic [AW-1:0]                       fw_cnt;
  logic [LANES-1:0]                    seen;
  logic [LANES-1:0][BIT_LENGTH-1:0]    lsum, lane_a, lane_b;
  logic                                start_acc, last_cap, row_done, last_row, op_ld;

  assign lsum  = lane_sum;
  assign mul_a = lane_a;
  assign mul_b = lane_b;

  // Kernel words occupy dbuf[0..N-1], window words dbuf[N..2N-1], in arrival order.
  always_comb begin
    start_acc = cStart && (state == IDLE || state == DONE);
    fifo_rd   = (state == LOAD) && !fifo_empty && (rd_cnt != CW'(NW));
    last_cap  = (state == LOAD) && rd_pend && (wr_cnt == CW'(NW - 1));
    row_done  = (state == WAIT) && (&(seen | mReady));
    last_row  = (row == KW'(LANES - 1));
    op_ld     = last_cap || (row_done && !last_row);
    row_sel   = row_done ? KW'(row + 1'b1) : '0;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [IW-1:0] kidx, widx;
    assign kidx = IW'(LANES * row_sel + g);
    assign widx = IW'(N + LANES * row_sel + g);

    conv_lane #(.BIT_LENGTH(BIT_LENGTH)) u_lane (
      .Clk   (Clk),
      .Rst   (Rst),
      .ld    (op_ld),
      .clr   (row_done || start_acc),
      .track (state == WAIT),
      .a_in  (dbuf[kidx]),
      .b_in  (dbuf[widx]),
      .rdy   (mReady[g]),
      .a     (lane_a[g]),
      .b     (lane_b[g]),
      .seen  (seen[g])
    );
  end

  // Strobes are set on the edge entering their state so each is high for that state only.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      cReady      <= 1'b0;
      mStart      <= '0;
      finalAdd    <= 1'b0;
      lane_clr    <= 1'b0;
      sum_clr     <= 1'b0;
      finalAddend <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      rd_pend     <= 1'b0;
      dbuf        <= '0;
      row         <= '0;
      k           <= '0;
      fw_cnt      <= '0;
    end else begin
      mStart   <= '0;
      finalAdd <= 1'b0;
      lane_clr <= 1'b0;
      sum_clr  <= 1'b0;
      rd_pend  <= fifo_rd;
      if (fifo_rd) rd_cnt <= rd_cnt + 1'b1;
      if (rd_pend) begin
        dbuf[wr_cnt[IW-1:0]] <= fifo_data;
        wr_cnt               <= wr_cnt + 1'b1;
      end
      case (state)
        IDLE, DONE: if (cStart) begin
          lane_clr <= 1'b1;
          sum_clr  <= 1'b1;
          cReady   <= 1'b0;
          rd_cnt   <= '0;
          wr_cnt   <= '0;
          row      <= '0;
          k        <= '0;
          fw_cnt   <= '0;
          state    <= LOAD;
        end
        LOAD: if (last_cap) begin
          mStart <= '1;
          state  <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (row_done) begin
          if (!last_row) begin
            row    <= row + 1'b1;
            mStart <= '1;
            state  <= ISSUE;
          end else begin
            finalAdd    <= 1'b1;
            finalAddend <= lsum[0];
            k           <= '0;
            state       <= FADD;
          end
        end
        FADD: begin
          fw_cnt <= '0;
          state  <= FWAIT;
        end
        FWAIT: if (fw_cnt == AW'(ADD_LAT - 1)) begin
          if (k == KW'(LANES - 1)) begin
            cReady <= 1'b1;
            state  <= DONE;
          end else begin
            k           <= k + 1'b1;
            finalAdd    <= 1'b1;
            finalAddend <= lsum[k + 1'b1];
            state       <= FADD;
          end
        end else begin
          fw_cnt <= fw_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: FIFO and multiplier-lane models around the DUT, with each
// run checked against operand/addend expectations derived from the pushed words.

module tb_conv_sequencer;
  localparam int W  = 32;
  localparam int L  = 3;
  localparam int AL = 4;
  localparam int N  = L * L;
  localparam int NW = 2 * N;

  logic           Clk = 1'b0, Rst = 1'b0, cStart = 1'b0;
  logic           cReady, fifo_rd, fifo_empty, lane_clr, finalAdd, sum_clr;
  logic [W-1:0]   fifo_data = '0, finalAddend;
  logic [L*W-1:0] mul_a, mul_b, lane_sum = '0;
  logic [L-1:0]   mStart, mReady = '0;

  int tests = 0, failed = 0;
  int cyc = 0, st = -1000;

  always #5 Clk = ~Clk;

  conv_sequencer #(.BIT_LENGTH(W), .LANES(L), .ADD_LAT(AL)) dut (
    .Clk(Clk), .Rst(Rst), .cStart(cStart), .cReady(cReady),
    .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .mul_a(mul_a), .mul_b(mul_b), .mStart(mStart), .mReady(mReady),
    .lane_clr(lane_clr), .lane_sum(lane_sum), .finalAdd(finalAdd),
    .finalAddend(finalAddend), .sum_clr(sum_clr)
  );

  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO model: word popped after a read cycle is presented for the whole following cycle.
  logic [W-1:0] fmem [0:511];
  int fr = 0, fw = 0;
  bit rd_seen = 0;
  assign fifo_empty = (fr >= fw);

  always @(posedge Clk) begin
    #1;
    if (rd_seen && fr < fw) begin
      fifo_data = fmem[fr];
      fr = fr + 1;
    end
  end

  // Lane model: lane i reports ready dly[i] cycles after mStart; lane 0 may repeat at dup_d.
  int dly [L];
  int dup_d = 0, maxd = 1;

  always @(posedge Clk) begin
    #1;
    mReady = '0;
    for (int i = 0; i < L; i++)
      if ((cyc - st) == dly[i] || (i == 0 && dup_d > 0 && (cyc - st) == dup_d)) mReady[i] = 1'b1;
  end

  // Event log of DUT strobes, sampled mid-cycle.
  int             ms_cyc[$], fa_cyc[$];
  logic [L-1:0]   ms_val[$];
  logic [L*W-1:0] ms_a[$], ms_b[$];
  logic [W-1:0]   fa_val[$];
  int n_reads = 0, rd_empty = 0, n_lclr = 0, n_sclr = 0;

  always @(negedge Clk) begin
    rd_seen = fifo_rd;
    if (fifo_rd) begin
      n_reads++;
      if (fifo_empty) rd_empty++;
    end
    if (mStart != '0) begin
      ms_cyc.push_back(cyc); ms_val.push_back(mStart);
      ms_a.push_back(mul_a); ms_b.push_back(mul_b);
      st = cyc;
    end
    if (finalAdd) begin
      fa_cyc.push_back(cyc); fa_val.push_back(finalAddend);
    end
    if (lane_clr) n_lclr++;
    if (sum_clr) n_sclr++;
  end

  logic [W-1:0] cur [NW];
  int b_rd, b_re, b_ms, b_fa, b_lc, b_sc;

  task automatic fill_random();
    for (int i = 0; i < NW; i++) cur[i] = $urandom;
    lane_sum = {$urandom, $urandom, $urandom};
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      fmem[fw] = cur[i];
      fw = fw + 1;
    end
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int dp);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dup_d = dp;
    maxd = d0;
    if (d1 > maxd) maxd = d1;
    if (d2 > maxd) maxd = d2;
    if (dp > maxd) maxd = dp;
  endtask

  task automatic mark_bases();
    b_rd = n_reads; b_re = rd_empty; b_ms = ms_cyc.size(); b_fa = fa_cyc.size();
    b_lc = n_lclr; b_sc = n_sclr;
  endtask

  task automatic start_conv();
    mark_bases();
    @(posedge Clk); #1 cStart = 1'b1;
    @(posedge Clk); #1 cStart = 1'b0;
  endtask

  // Runs the tail of a convolution and checks everything it produced against cur/lane_sum.
  task automatic test_conv_run(input string nm);
    bit done = 0;
    int nms, nfa;
    logic [L*W-1:0] ea, eb;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (cReady === 1'b1) begin done = 1; break; end
    end
    tests++;
    if (!done) begin
      failed++; $display("FAIL %s done: cReady still %b after 3000 cycles, want 1", nm, cReady);
      return;
    end
    tests++;
    if (n_reads - b_rd !== NW) begin
      failed++; $display("FAIL %s reads: got %0d want %0d", nm, n_reads - b_rd, NW);
    end
    tests++;
    if (rd_empty - b_re !== 0) begin
      failed++; $display("FAIL %s read_on_empty: got %0d want 0", nm, rd_empty - b_re);
    end
    nms = ms_cyc.size() - b_ms;
    tests++;
    if (nms !== L) begin
      failed++; $display("FAIL %s mstart_count: got %0d want %0d", nm, nms, L);
    end else begin
      for (int r = 0; r < L; r++) begin
        for (int i = 0; i < L; i++) begin
          ea[i*W +: W] = cur[L*r + i];
          eb[i*W +: W] = cur[N + L*r + i];
        end
        tests++;
        if ({ms_a[b_ms+r], ms_b[b_ms+r], ms_val[b_ms+r]} !== {ea, eb, {L{1'b1}}}) begin
          failed++;
          $display("FAIL %s row%0d operands: got a=%h b=%h ms=%b want a=%h b=%h ms=all-ones",
                   nm, r, ms_a[b_ms+r], ms_b[b_ms+r], ms_val[b_ms+r], ea, eb);
        end
        if (r > 0) begin
          tests++;
          if (ms_cyc[b_ms+r] - ms_cyc[b_ms+r-1] < maxd + 1) begin
            failed++; $display("FAIL %s row%0d mstart_gap: got %0d want >= %0d", nm, r,
                               ms_cyc[b_ms+r] - ms_cyc[b_ms+r-1], maxd + 1);
          end
        end
      end
    end
    nfa = fa_cyc.size() - b_fa;
    tests++;
    if (nfa !== L) begin
      failed++; $display("FAIL %s finaladd_count: got %0d want %0d", nm, nfa, L);
    end else begin
      for (int kk = 0; kk < L; kk++) begin
        tests++;
        if (fa_val[b_fa+kk] !== lane_sum[kk*W +: W]) begin
          failed++; $display("FAIL %s addend%0d: got %h want %h", nm, kk, fa_val[b_fa+kk],
                             lane_sum[kk*W +: W]);
        end
        tests++;
        if (kk > 0 && fa_cyc[b_fa+kk] - fa_cyc[b_fa+kk-1] !== AL + 1) begin
          failed++; $display("FAIL %s addend%0d spacing: got %0d want %0d", nm, kk,
                             fa_cyc[b_fa+kk] - fa_cyc[b_fa+kk-1], AL + 1);
        end else if (kk == 0 && nms == L && fa_cyc[b_fa] - ms_cyc[b_ms+L-1] < maxd + 1) begin
          failed++; $display("FAIL %s first_finaladd early: got gap %0d want >= %0d", nm,
                             fa_cyc[b_fa] - ms_cyc[b_ms+L-1], maxd + 1);
        end
      end
    end
    tests++;
    if ({n_lclr - b_lc, n_sclr - b_sc} !== {32'd1, 32'd1}) begin
      failed++; $display("FAIL %s clr_pulses: got lane_clr=%0d sum_clr=%0d want 1 and 1", nm,
                         n_lclr - b_lc, n_sclr - b_sc);
    end
    repeat (3) @(negedge Clk);
    tests++;
    if (cReady !== 1'b1) begin
      failed++; $display("FAIL %s cready_hold: got %b want 1", nm, cReady);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({cReady, fifo_rd, mStart, finalAdd, lane_clr, sum_clr} !== '0) begin
      failed++; $display("FAIL reset strobes: got %b want 0",
                         {cReady, fifo_rd, mStart, finalAdd, lane_clr, sum_clr});
    end
    tests++;
    if ({mul_a, mul_b, finalAddend} !== '0) begin
      failed++; $display("FAIL reset data: got a=%h b=%h addend=%h want 0", mul_a, mul_b, finalAddend);
    end
    @(posedge Clk); #1 Rst = 1'b1;
    repeat (3) @(negedge Clk);
    tests++;
    if ({cReady, fifo_rd, lane_clr} !== 3'b000) begin
      failed++; $display("FAIL idle_after_reset: got %b want 000", {cReady, fifo_rd, lane_clr});
    end
  endtask

  task automatic test_nominal();
    logic [W-1:0] k9 [N];
    k9 = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
           32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};
    for (int i = 0; i < N; i++) begin
      cur[i] = k9[i];
      cur[N+i] = 32'h3f800000;
    end
    lane_sum = {32'h42340000, 32'h41f00000, 32'h40c00000};
    set_delays(1, 1, 1, 0);
    push_range(0, NW - 1);
    start_conv();
    test_conv_run("nominal");
  endtask

  task automatic test_underflow();
    int r0;
    bit got7 = 0;
    fill_random();
    set_delays(2, 3, 1, 0);
    push_range(0, 6);
    start_conv();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (n_reads - b_rd == 7) begin got7 = 1; break; end
    end
    tests++;
    if (!got7) begin
      failed++; $display("FAIL underflow first7: got %0d reads want 7", n_reads - b_rd);
    end
    r0 = n_reads;
    repeat (20) @(negedge Clk);
    tests++;
    if (n_reads !== r0) begin
      failed++; $display("FAIL underflow stall_reads: got %0d want 0", n_reads - r0);
    end
    push_range(7, NW - 1);
    test_conv_run("underflow");
  endtask

  task automatic test_skewed_ready();
    fill_random();
    set_delays(1, 5, 9, 3);
    push_range(0, NW - 1);
    start_conv();
    test_conv_run("skewed");
  endtask

  task automatic test_busy_start();
    bit seen_ms = 0;
    fill_random();
    set_delays(4, 6, 5, 0);
    push_range(0, NW - 1);
    start_conv();
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (ms_cyc.size() > b_ms) begin seen_ms = 1; break; end
    end
    tests++;
    if (!seen_ms) begin
      failed++; $display("FAIL busy first_mstart: got none within 300 cycles want 1");
    end
    @(posedge Clk); #1 cStart = 1'b1;
    @(posedge Clk); #1 cStart = 1'b0;
    test_conv_run("busy_start");
  endtask

  task automatic test_reset_mid_wait();
    bit seen_ms = 0;
    int r0;
    fill_random();
    set_delays(6, 7, 8, 0);
    push_range(0, NW - 1);
    start_conv();
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (ms_cyc.size() > b_ms) begin seen_ms = 1; break; end
    end
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    tests++;
    if (!seen_ms || {cReady, fifo_rd, mStart, finalAdd, lane_clr, sum_clr, mul_a, mul_b, finalAddend} !== '0) begin
      failed++; $display("FAIL reset_mid async_clear: got strobes=%b a=%h b=%h want all 0 (mstart seen %0d)",
                         {cReady, fifo_rd, mStart, finalAdd, lane_clr, sum_clr}, mul_a, mul_b, seen_ms);
    end
    @(posedge Clk); #1 Rst = 1'b1;
    fill_random();
    set_delays(2, 1, 3, 0);
    push_range(0, NW - 1);
    r0 = n_reads;
    repeat (6) @(negedge Clk);
    tests++;
    if (n_reads !== r0 || cReady !== 1'b0) begin
      failed++; $display("FAIL reset_mid idle: got reads=%0d cReady=%b want 0 and 0", n_reads - r0, cReady);
    end
    start_conv();
    test_conv_run("after_reset");
  endtask

  task automatic test_back_to_back();
    fill_random();
    set_delays(3, 2, 1, 0);
    push_range(0, NW - 1);
    mark_bases();
    @(posedge Clk); #1 cStart = 1'b1;
    @(negedge Clk);
    tests++;
    if ({cReady, fifo_rd} !== 2'b10) begin
      failed++; $display("FAIL b2b start_cycle: got cReady,fifo_rd=%b want 10", {cReady, fifo_rd});
    end
    @(posedge Clk); #1 cStart = 1'b0;
    tests++;
    if ({cReady, lane_clr, sum_clr} !== 3'b011) begin
      failed++; $display("FAIL b2b accept: got cReady,lane_clr,sum_clr=%b want 011",
                         {cReady, lane_clr, sum_clr});
    end
    test_conv_run("back_to_back");
  endtask

  task automatic test_random();
    int d0, d1, d2, dp;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      d0 = $urandom_range(1, 8); d1 = $urandom_range(1, 8); d2 = $urandom_range(1, 8);
      dp = 0;
      if (d1 > d0 + 1) dp = $urandom_range(d0 + 1, d1);
      set_delays(d0, d1, d2, dp);
      push_range(0, NW - 1);
      start_conv();
      test_conv_run("random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underflow();
    test_skewed_ready();
    test_busy_start();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
